// File: rtl/sequence_generator_pkg.sv
// rtl/sequence_generator_pkg.sv - shared constants and state encoding for the sequence generator
package sequence_generator_pkg;

  localparam int MAX_LEN_DEF = 16;
  localparam int LEN_W       = $clog2(MAX_LEN_DEF) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/seq_tx_shifter.sv
// rtl/seq_tx_shifter.sv - loadable MSB-first shift register with remaining-bit counter
module seq_tx_shifter
  import sequence_generator_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LW      = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               restart,
  input  logic               advance,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LW-1:0]      len_in,
  output logic               bit_out,
  output logic               last
);

  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic [MAX_LEN-1:0] sr;
  logic [LW-1:0]      cnt;

  // Left-justify the pattern so pattern[len-1] sits in the MSB; bits above len fall off.
  function automatic logic [MAX_LEN-1:0] align(input logic [MAX_LEN-1:0] p,
                                               input logic [LW-1:0] l);
    logic [LW-1:0] sh;
    sh = LW'(MAX_LEN) - l;
    return p << sh;
  endfunction

  // Bits still to come after the one currently presented.
  function automatic logic [LW-1:0] first_cnt(input logic [LW-1:0] l);
    return (l == '0) ? '0 : l - LW'(1);
  endfunction

  // Load a new job, replay the latched pattern, or step to the next bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= '0;
      len_q <= '0;
      sr    <= '0;
      cnt   <= '0;
    end else if (load) begin
      pat_q <= pattern_in;
      len_q <= len_in;
      sr    <= align(pattern_in, len_in);
      cnt   <= first_cnt(len_in);
    end else if (restart) begin
      sr    <= align(pat_q, len_q);
      cnt   <= first_cnt(len_q);
    end else if (advance) begin
      sr    <= {sr[MAX_LEN-2:0], 1'b0};
      cnt   <= (cnt == '0) ? '0 : cnt - LW'(1);
    end
  end

  assign bit_out = sr[MAX_LEN-1];
  assign last    = (cnt == '0);

endmodule

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - repeating serial pattern generator with gaps, abort and done pulse
module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int REP_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [MAX_LEN-1:0]       pattern,
  input  logic [$clog2(MAX_LEN):0] len,
  input  logic [REP_W-1:0]         reps,
  input  logic [3:0]               gap,
  input  logic                     abort,
  output logic                     x,
  output logic                     x_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int LW = $clog2(MAX_LEN) + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_SEND = S_SEND;
  localparam logic [1:0] ST_GAP  = S_GAP;
  localparam logic [1:0] ST_DONE = S_DONE;

  logic [1:0]       state;
  logic [REP_W-1:0] rep_cnt;
  logic [3:0]       gap_q;
  logic [3:0]       gap_cnt;
  logic             x_valid_q;

  logic [LW-1:0]    len_c;
  logic             accept;
  logic             degenerate;
  logic             rep_left;
  logic             last_bit;
  logic             sh_load;
  logic             sh_restart;
  logic             sh_advance;
  logic             sh_bit;
  logic             sh_last;

  // Handshake, length clamp and shifter control derived from the current state.
  always_comb begin
    len_c      = (len > LEN_MAX) ? LEN_MAX : len;
    accept     = (state == ST_IDLE) && load_valid && !abort;
    degenerate = (len_c == '0) || (reps == '0);
    rep_left   = (rep_cnt != '0);
    last_bit   = (state == ST_SEND) && x_valid_q && sh_last;
    sh_load    = accept;
    sh_advance = (state == ST_SEND) && x_valid_q && !sh_last && !abort;
    sh_restart = !abort &&
                 ((last_bit && rep_left && (gap_q == 4'd0)) ||
                  ((state == ST_GAP) && (gap_cnt <= 4'd1)));
  end

  seq_tx_shifter #(
    .MAX_LEN(MAX_LEN),
    .LW     (LW)
  ) u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (sh_load),
    .restart   (sh_restart),
    .advance   (sh_advance),
    .pattern_in(pattern),
    .len_in    (len_c),
    .bit_out   (sh_bit),
    .last      (sh_last)
  );

  // Job FSM with repeat and gap counters; a SEND cycle with x_valid low marks an empty job.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rep_cnt   <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      x_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SEND;
            gap_q     <= gap;
            gap_cnt   <= '0;
            x_valid_q <= !degenerate;
            rep_cnt   <= degenerate ? '0 : reps - REP_W'(1);
          end
        end
        ST_SEND: begin
          if (abort) begin
            state     <= ST_IDLE;
            x_valid_q <= 1'b0;
          end else if (!x_valid_q) begin
            state     <= ST_DONE;
          end else if (sh_last) begin
            if (rep_left) begin
              rep_cnt <= rep_cnt - REP_W'(1);
              if (gap_q != 4'd0) begin
                state     <= ST_GAP;
                gap_cnt   <= gap_q;
                x_valid_q <= 1'b0;
              end
            end else begin
              state     <= ST_DONE;
              x_valid_q <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (abort) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else if (gap_cnt <= 4'd1) begin
            state     <= ST_SEND;
            gap_cnt   <= '0;
            x_valid_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          x_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = (state == ST_IDLE) && !abort;
  assign x          = sh_bit & x_valid_q;
  assign x_valid    = x_valid_q;
  assign busy       = (state == ST_SEND) || (state == ST_GAP);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - randomized self-checking bench for sequence_generator
module tb_sequence_generator;

  localparam int ML = 16;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load_valid;
  logic          load_ready;
  logic [ML-1:0] pattern;
  logic [4:0]    len;
  logic [RW-1:0] reps;
  logic [3:0]    gap;
  logic          abort;
  logic          x;
  logic          x_valid;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit xv;
    bit xb;
    bit dn;
  } exp_t;

  exp_t exp_q[$];
  bit   obs[$];

  always #5 clk = ~clk;

  sequence_generator #(.MAX_LEN(ML), .REP_W(RW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .pattern   (pattern),
    .len       (len),
    .reps      (reps),
    .gap       (gap),
    .abort     (abort),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy),
    .done      (done)
  );

  // Expected per-cycle outputs starting the cycle after accept.
  function automatic void build(input logic [ML-1:0] p, input int l, input int r, input int g);
    int le;
    exp_q.delete();
    le = (l > ML) ? ML : l;
    if (le == 0 || r == 0) begin
      exp_q.push_back('{xv: 1'b0, xb: 1'b0, dn: 1'b0});
    end else begin
      for (int rep = 0; rep < r; rep++) begin
        if (rep > 0)
          for (int k = 0; k < g; k++) exp_q.push_back('{xv: 1'b0, xb: 1'b0, dn: 1'b0});
        for (int i = le - 1; i >= 0; i--) exp_q.push_back('{xv: 1'b1, xb: p[i], dn: 1'b0});
      end
    end
    exp_q.push_back('{xv: 1'b0, xb: 1'b0, dn: 1'b1});
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!load_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s wait_ready: load_ready=%b required 1", tag, load_ready);
    end
  endtask

  task automatic check_stream(input string tag);
    foreach (exp_q[k]) begin
      total++;
      if (x_valid !== exp_q[k].xv || x !== exp_q[k].xb || done !== exp_q[k].dn ||
          busy !== !exp_q[k].dn || load_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s cycle %0d: xv/x/done/busy/rdy=%b%b%b%b%b required %b%b%b%b0",
                 tag, k, x_valid, x, done, busy, load_ready,
                 exp_q[k].xv, exp_q[k].xb, exp_q[k].dn, !exp_q[k].dn);
      end
      if (x_valid === 1'b1) obs.push_back(x);
      @(negedge clk);
    end
    total++;
    if (load_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || x_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s end: rdy/busy/done/xv=%b%b%b%b required 1000",
               tag, load_ready, busy, done, x_valid);
    end
  endtask

  task automatic run_job(input logic [ML-1:0] p, input int l, input int r, input int g,
                         input string tag);
    build(p, l, r, g);
    obs.delete();
    wait_ready(tag);
    pattern    = p;
    len        = 5'(l);
    reps       = RW'(r);
    gap        = 4'(g);
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    pattern    = ML'($urandom);
    len        = 5'($urandom);
    reps       = RW'($urandom);
    gap        = 4'($urandom);
    check_stream(tag);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load_valid = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; reps = '0; gap = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({x, x_valid, busy, done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: x/xv/busy/done=%b%b%b%b required 0000", x, x_valid, busy, done);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: load_ready=%b required 1", load_ready);
    end
  endtask

  task automatic test_back_to_back();
    int hits = 0;
    run_job(16'h000B, 4, 2, 0, "b2b");
    for (int i = 3; i < obs.size(); i++)
      if ({obs[i-3], obs[i-2], obs[i-1], obs[i]} == 4'b1011) hits++;
    total++;
    if (obs.size() != 8 || hits != 2) begin
      bad++;
      $display("FAIL b2b_detect: bits=%0d hits=%0d required bits=8 hits=2", obs.size(), hits);
    end
  endtask

  task automatic test_gap();
    run_job(16'h000B, 4, 3, 2, "gap");
  endtask

  task automatic test_degenerate();
    run_job(16'hFFFF, 0, 3, 1, "len0");
    run_job(16'h000B, 4, 0, 1, "reps0");
  endtask

  task automatic test_clamp();
    run_job(16'hA5C3, 20, 1, 0, "clamp");
  endtask

  task automatic test_abort();
    logic [ML-1:0] p;
    p = ML'($urandom);
    wait_ready("abort");
    pattern = p; len = 5'd8; reps = 8'd1; gap = 4'd0; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (x_valid !== 1'b1 || x !== p[7-i]) begin
        bad++;
        $display("FAIL abort_bit%0d: xv/x=%b%b required 1%b", i, x_valid, x, p[7-i]);
      end
      if (i == 2) abort = 1'b1;
      @(negedge clk);
    end
    total++;
    if (x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_stop: xv/busy/done=%b%b%b required 000", x_valid, busy, done);
    end
    abort = 1'b0;
    #1;
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_ready: load_ready=%b required 1", load_ready);
    end
    repeat (6) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || x_valid !== 1'b0) begin
        bad++;
        $display("FAIL abort_quiet: done/xv=%b%b required 00", done, x_valid);
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    wait_ready("rst_gap");
    pattern = 16'h000B; len = 5'd4; reps = 8'd3; gap = 4'd5; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1 || x_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_gap_in_gap: busy/xv=%b%b required 10", busy, x_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({x, x_valid, busy, done} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_gap_async: x/xv/busy/done=%b%b%b%b required 0000", x, x_valid, busy, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_job(16'h000B, 4, 1, 0, "after_reset");
  endtask

  task automatic test_abort_idle();
    wait_ready("abort_idle");
    abort = 1'b1; load_valid = 1'b1;
    pattern = 16'h000B; len = 5'd4; reps = 8'd1; gap = 4'd0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (load_ready !== 1'b0 || busy !== 1'b0 || x_valid !== 1'b0) begin
        bad++;
        $display("FAIL abort_idle_hold: rdy/busy/xv=%b%b%b required 000", load_ready, busy, x_valid);
      end
    end
    abort = 1'b0;
    build(16'h000B, 4, 1, 0);
    @(negedge clk);
    load_valid = 1'b0;
    check_stream("abort_idle");
  endtask

  task automatic test_random();
    for (int j = 0; j < 25; j++)
      run_job(ML'($urandom), $urandom_range(0, 20), $urandom_range(0, 3),
              $urandom_range(0, 3), $sformatf("rand%0d", j));
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_degenerate();
    test_clamp();
    test_abort();
    test_reset_mid_gap();
    test_abort_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
